// File: rtl/fft_seq_ctrl.sv
// Address/strobe sequencer for one in-place radix-2 DIT pass of a 32-point FFT.
// Reads are issued stage by stage; write-back trails each read by BFLY_LAT cycles.
module fft_seq_ctrl #(
   parameter int ADDRSIZE    = 5,
   parameter int NUMADDR     = 32,
   parameter int NUMSTAGES   = 5,
   parameter int TW_ADDRSIZE = 4,
   parameter int BFLY_LAT    = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic [2:0]             stage_num,
   output logic [3:0]             bfly_cnt,
   output logic                   rd_en,
   output logic [ADDRSIZE-1:0]    rd_addr_a,
   output logic [ADDRSIZE-1:0]    rd_addr_b,
   output logic                   tw_cs,
   output logic [TW_ADDRSIZE-1:0] tw_addr,
   output logic                   wr_en,
   output logic [ADDRSIZE-1:0]    wr_addr_a,
   output logic [ADDRSIZE-1:0]    wr_addr_b
);

   localparam int         DW         = (BFLY_LAT > 1) ? $clog2(BFLY_LAT) : 1;
   localparam logic [2:0] LAST_STAGE = 3'(NUMSTAGES - 1);
   localparam logic [3:0] LAST_BFLY  = 4'(NUMADDR / 2 - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_FIN   = 2'd3
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [2:0]      r_stage, w_stage_nxt;
   logic [3:0]      r_j, w_j_nxt;
   logic [DW-1:0]   r_drain, w_drain_nxt;

   logic [BFLY_LAT-1:0] r_dl_v;
   logic [ADDRSIZE-1:0] r_dl_a [BFLY_LAT];
   logic [ADDRSIZE-1:0] r_dl_b [BFLY_LAT];

   function automatic logic [ADDRSIZE-1:0] f_pos(input logic [2:0] s, input logic [3:0] j);
      logic [ADDRSIZE-1:0] w_half;
      w_half = ADDRSIZE'(1) << s;
      return ADDRSIZE'(j) & (w_half - ADDRSIZE'(1));
   endfunction

   // Upper input address: group base (group * 2 * half) plus position inside the group.
   function automatic logic [ADDRSIZE-1:0] f_addr_a(input logic [2:0] s, input logic [3:0] j);
      return ((ADDRSIZE'(j) >> s) << (s + 3'd1)) | f_pos(s, j);
   endfunction

   function automatic logic [ADDRSIZE-1:0] f_addr_b(input logic [2:0] s, input logic [3:0] j);
      return f_addr_a(s, j) + (ADDRSIZE'(1) << s);
   endfunction

   function automatic logic [TW_ADDRSIZE-1:0] f_tw(input logic [2:0] s, input logic [3:0] j);
      return TW_ADDRSIZE'(f_pos(s, j) << (LAST_STAGE - s));
   endfunction

   assign stage_num = r_stage;
   assign bfly_cnt  = r_j;
   assign wr_en     = r_dl_v[BFLY_LAT-1];
   assign wr_addr_a = r_dl_a[BFLY_LAT-1];
   assign wr_addr_b = r_dl_b[BFLY_LAT-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_stage <= 3'd0;
         r_j     <= 4'd0;
         r_drain <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_stage <= w_stage_nxt;
         r_j     <= w_j_nxt;
         r_drain <= w_drain_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_stage_nxt = r_stage;
      w_j_nxt     = r_j;
      w_drain_nxt = r_drain;
      case (r_state)
         S_IDLE: begin
            w_stage_nxt = 3'd0;
            w_j_nxt     = 4'd0;
            if (start) begin
               w_state_nxt = S_ISSUE;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_ISSUE: begin
            if (r_j == LAST_BFLY) begin
               w_state_nxt = S_DRAIN;
               w_drain_nxt = DW'(BFLY_LAT - 1);
            end else begin
               w_j_nxt = r_j + 4'd1;
            end
         end
         // Drain keeps the next stage's reads behind this stage's last write-back.
         S_DRAIN: begin
            if (r_drain == '0) begin
               if (r_stage == LAST_STAGE) begin
                  w_state_nxt = S_FIN;
               end else begin
                  w_state_nxt = S_ISSUE;
                  w_stage_nxt = r_stage + 3'd1;
                  w_j_nxt     = 4'd0;
               end
            end else begin
               w_drain_nxt = r_drain - DW'(1);
            end
         end
         S_FIN: begin
            w_state_nxt = S_IDLE;
            w_stage_nxt = 3'd0;
            w_j_nxt     = 4'd0;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_stage_nxt = 3'd0;
            w_j_nxt     = 4'd0;
            w_drain_nxt = '0;
         end
      endcase
   end

   // Outputs are registered from the next-state values so they line up with r_state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         rd_en     <= 1'b0;
         tw_cs     <= 1'b0;
         rd_addr_a <= '0;
         rd_addr_b <= '0;
         tw_addr   <= '0;
      end else begin
         busy  <= (w_state_nxt == S_ISSUE) || (w_state_nxt == S_DRAIN);
         done  <= (w_state_nxt == S_FIN);
         rd_en <= (w_state_nxt == S_ISSUE);
         tw_cs <= (w_state_nxt == S_ISSUE);
         if (w_state_nxt == S_ISSUE) begin
            rd_addr_a <= f_addr_a(w_stage_nxt, w_j_nxt);
            rd_addr_b <= f_addr_b(w_stage_nxt, w_j_nxt);
            tw_addr   <= f_tw(w_stage_nxt, w_j_nxt);
         end else if (w_state_nxt == S_IDLE) begin
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_addr   <= '0;
         end else begin
            rd_addr_a <= rd_addr_a;
            rd_addr_b <= rd_addr_b;
            tw_addr   <= tw_addr;
         end
      end
   end

   // Write-back delay line: slot 0 captures the read issued in the current cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dl_v <= '0;
         for (int i = 0; i < BFLY_LAT; i++) begin
            r_dl_a[i] <= '0;
            r_dl_b[i] <= '0;
         end
      end else begin
         r_dl_v[0] <= rd_en;
         r_dl_a[0] <= rd_addr_a;
         r_dl_b[0] <= rd_addr_b;
         for (int i = 1; i < BFLY_LAT; i++) begin
            r_dl_v[i] <= r_dl_v[i-1];
            r_dl_a[i] <= r_dl_a[i-1];
            r_dl_b[i] <= r_dl_b[i-1];
         end
      end
   end

endmodule

// File: doc/fft_seq_ctrl.md
Name: fft_seq_ctrl

Overview:
- Sequences one in-place radix-2 DIT pass of the 32-point FFT: 5 stages of 16 butterflies each.
- For every butterfly it issues the data-RAM read address pair and drives chip-select and address to the twiddle ROM.
- It writes each result back to the same address pair after a fixed butterfly pipeline latency.
- It sits between the top-level start/done handshake and the data RAM, twiddle ROM and butterfly datapath.

Parameters:
ADDRSIZE, 5, data RAM address width
NUMADDR, 32, FFT points
NUMSTAGES, 5, log2(NUMADDR)
TW_ADDRSIZE, 4, twiddle ROM address width (NUMADDR/2 entries)
BFLY_LAT, 3, cycles from read issue to write-back of the same butterfly (min 1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to run a full FFT
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when the last write-back completes
stage_num  out  3  stage currently issuing reads (0..4)
bfly_cnt  out  4  butterfly index j currently issuing (0..15)
rd_en  out  1  data RAM read strobe
rd_addr_a  out  ADDRSIZE  upper butterfly input address
rd_addr_b  out  ADDRSIZE  lower butterfly input address
tw_cs  out  1  twiddle ROM chip select, equal to rd_en
tw_addr  out  TW_ADDRSIZE  twiddle index k (W_32^k)
wr_en  out  1  data RAM write strobe
wr_addr_a  out  ADDRSIZE  write address for the A output
wr_addr_b  out  ADDRSIZE  write address for the B output

Behaviour:
- All outputs are registered.
- Reset (async assert, sync release): state IDLE; every output is 0; the delay line is cleared.
- An rst_n assertion mid-run aborts the run immediately. No done pulse is produced. Writes still in flight are dropped.
- States:
  - IDLE: start=1 -> ISSUE with stage=0, j=0. Otherwise stay.
  - ISSUE: rd_en=tw_cs=1 every cycle. j increments each cycle. At j=15 -> DRAIN with a drain counter of BFLY_LAT.
  - DRAIN: rd_en=0 for BFLY_LAT cycles.
    - On exit with stage<4: stage+1, j=0 -> ISSUE.
    - On exit with stage=4 -> FIN.
  - FIN: done=1 and busy=0 for one cycle -> IDLE.
- Address generation for stage s and butterfly j:
  - half = 1<<s
  - pos = j & (half-1)
  - group = j >> s
  - rd_addr_a = group*2*half + pos
  - rd_addr_b = rd_addr_a + half
  - tw_addr = pos << (NUMSTAGES-1-s)
  - All arithmetic is unsigned and truncated to the port width. No wrap occurs for legal s and j.
- Twiddle ROM is synchronous: twiddle data is valid the cycle after tw_cs. The datapath absorbs this inside BFLY_LAT.
- Write-back: a BFLY_LAT-deep shift register carries {valid, addr_a, addr_b}.
  - A read issued during cycle c produces wr_en=1 with the same addresses during cycle c+BFLY_LAT.
- Hazard rule: the first read of stage s+1 occurs strictly after the last write of stage s. No overlap between stages.
- Timing, with start sampled at edge 0:
  - busy=1 from cycle 1.
  - Stage s issues reads during cycles s*(16+BFLY_LAT)+1 .. s*(16+BFLY_LAT)+16.
  - The last write is in cycle 5*(16+BFLY_LAT). With the default BFLY_LAT this is cycle 95.
  - done=1 in cycle 5*(16+BFLY_LAT)+1 (96 with default); busy falls in the same cycle.
- start while busy or in FIN is ignored. It is not queued.
- A new start in the cycle after FIN is accepted.
- bfly_cnt and stage_num hold their last values during DRAIN and return to 0 in IDLE.

Test Plan:
- Reset check: hold rst_n=0 and pulse start. All outputs stay 0. Release, wait 10 cycles -> busy=0, rd_en=0.
- Stage 0 addresses: start. Cycle 1: a=0, b=1, k=0. Cycle 8 (j=7): a=14, b=15, k=0. wr_en cycle 4: wr a=0, b=1.
- Mid stages: stage 2 j=5 -> a=9, b=13, k=4. Stage 3 j=9 -> a=17, b=25, k=2.
- Stage 4 and completion: j=0 -> a=0, b=16, k=0. j=15 -> a=15, b=31, k=15. Last wr_en in cycle 95; done pulse in cycle 96 only; busy 1 in cycles 1..95.
- Hazard and count: wr_en is high in exactly 80 cycles. rd_en is never high within BFLY_LAT cycles after a stage's last issue. Repeat with BFLY_LAT=1 -> done in cycle 86.
- Protocol and abort: start pulse in cycle 40 -> no effect, and done still occurs once. Assert rst_n=0 in cycle 50 -> all outputs 0 asynchronously. Release, then start -> a clean full run with done in cycle 96.
